mips_seq_shifter: RTL and testbench
===================================

// Module: mips_seq_shifter
// PURPOSE
//  Parametrised multi-cycle shifter for the MIPS datapath; successor to the fixed shift-left-by-two block.
//  Variable-amount SLL/SRL/SRA (optional ROTR) on a WIDTH-bit operand.
//  Iterates at most STEP bit positions per cycle, trading latency for shifter area.
//  Start/Busy/Done handshake with the control unit; the ALU result mux reads Result on Done.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; >= 2.
//  STEP    4  max bit positions shifted per cycle; power of two, 1..WIDTH.
//  SHW    $clog2(WIDTH)  localparam, derived; shift-amount width.
// PORTS
//  CLK      in   1      clock; all state updates on rising edge.
//  RST      in   1      synchronous reset, active-high.
//  Start    in   1      request; sampled only while Busy=0.
//  Op       in   2      00 SLL, 01 SRL, 10 SRA, 11 ROTR (needs macro).
//  Shamt    in   SHW    shift amount 0..WIDTH-1.
//  Data_in  in   WIDTH  operand.
//  Result   out  WIDTH  registered result; updates only on entry to DONE.
//  Busy     out  1      high in SHIFT state.
//  Done     out  1      one-cycle pulse; Result valid and held until next completion.
// BEHAVIOUR
//  Reset (RST=1 at edge): state IDLE; Result=0, Busy=0, Done=0; work regs cleared. Aborts any op mid-shift, no Done.
//  States: IDLE, SHIFT, DONE. Busy=1 only in SHIFT; Done=1 only in DONE.
//  IDLE/DONE + Start=1: capture Data_in, Op, Shamt into work regs; remaining=Shamt.
//    remaining==0 or no-op code -> DONE next cycle with Result=Data_in; else -> SHIFT.
//  DONE + Start=0 -> IDLE. Back-to-back Start in DONE accepted (no bubble).
//  SHIFT: per cycle shift work reg by k=min(STEP,remaining); remaining-=k; remaining reaches 0 -> DONE, Result<=work.
//  Start while Busy=1 ignored; inputs not re-sampled.
//  Latency: Start at edge t -> Done high in cycle t+1+ceil(Shamt/STEP).
//  SLL fills zeros at LSB; SRL fills zeros at MSB; SRA fills captured bit WIDTH-1.
//  Shamt always < WIDTH by construction; no overflow handling needed.
//  Result stable throughout SHIFT (separate work register).
// CONFIGURATION
//  SEQ_SHIFTER_ROTATE_EN defined: Op=11 is ROTR; bits leaving LSB re-enter at MSB, same latency as shifts.
//  Not defined: Op=11 is a no-op: Result=Data_in, Done at t+1, no SHIFT cycles.
// STRUCTURE
//  Package mips_shift_pkg: shift_op_t enum (SLL=2'b00, SRL=2'b01, SRA=2'b10, ROTR=2'b11),
//    state enum shstate_t, constant OP_W=2.
//  Sub-module mips_shift_step: combinational single-step shifter, inputs (data, op, k<=STEP, fill) -> shifted data;
//    instanced once; FSM, counter and registers stay in mips_seq_shifter.
// TESTING (WIDTH=32, STEP=4 unless stated)
//  SLL Data_in=0x0000_0001 Shamt=2 -> Result=0x0000_0004, Done at t+2, Busy high 1 cycle.
//  SRA Data_in=0x8000_0000 Shamt=31 -> Result=0xFFFF_FFFF, Done at t+9; SRL same -> 0x0000_0001.
//  Shamt=0 any Op -> Result=Data_in, Done at t+1, Busy never high; back-to-back Start in DONE accepted.
//  Start pulsed at t+2 with new operand during 8-cycle SRA -> ignored; Result matches first op only.
//  RST at t+3 mid-shift -> next cycle Result=0, Busy=0, Done=0; no Done pulse afterwards.
//  ROTR Data_in=0x0000_00F1 Shamt=4: with macro -> 0x1000_000F at t+2; without -> 0x0000_00F1 at t+1.

Source files
------------

// File: rtl/mips_shift_pkg.sv
// Shared types for the MIPS sequential shifter: shift opcodes, FSM states and the opcode width.
package mips_shift_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    SLL  = 2'b00,
    SRL  = 2'b01,
    SRA  = 2'b10,
    ROTR = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shstate_t;

endpackage

// File: rtl/mips_shift_step.sv
// Combinational single-step shifter: moves data by k (0..STEP) positions for one FSM iteration.
module mips_shift_step
  import mips_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int KW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  input  shift_op_t        op_i,
  input  logic [KW-1:0]    k_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] data_o
);

  logic [2*WIDTH-1:0] ext;
  logic [2*WIDTH-1:0] ext_sh;

  // Right-going ops share one double-width shift; the upper half supplies the incoming bits.
  always_comb begin
    ext = {{WIDTH{1'b0}}, data_i};
    case (op_i)
      SRA:     ext = {{WIDTH{fill_i}}, data_i};
      ROTR:    ext = {data_i, data_i};
      default: ext = {{WIDTH{1'b0}}, data_i};
    endcase
    ext_sh = ext >> k_i;
    if (op_i == SLL) begin
      data_o = data_i << k_i;
    end else begin
      data_o = ext_sh[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mips_seq_shifter.sv
// Multi-cycle SLL/SRL/SRA shifter, at most STEP positions per cycle, Start/Busy/Done handshake.
// Define SEQ_SHIFTER_ROTATE_EN to turn Op=11 into ROTR; otherwise Op=11 passes Data_in through.
module mips_seq_shifter
  import mips_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic [OP_W-1:0]   Op,
  input  logic [SHW-1:0]    Shamt,
  input  logic [WIDTH-1:0]  Data_in,
  output logic [WIDTH-1:0]  Result,
  output logic              Busy,
  output logic              Done
);

  localparam int KW = $clog2(STEP + 1);
  localparam logic [SHW:0] STEP_EXT = (SHW + 1)'(STEP);

`ifdef SEQ_SHIFTER_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  shstate_t          state_q, state_d;
  shift_op_t         op_q, op_d;
  logic [WIDTH-1:0]  work_q, work_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [SHW-1:0]    rem_q, rem_d;
  logic              fill_q, fill_d;

  logic [KW-1:0]     k;
  logic [SHW-1:0]    rem_nxt;
  logic [WIDTH-1:0]  step_out;
  shift_op_t         op_in;
  logic              passthru;

  assign op_in    = shift_op_t'(Op);
  assign passthru = (Shamt == '0) || ((op_in == ROTR) && !ROT_EN);

  assign k       = ({1'b0, rem_q} >= STEP_EXT) ? KW'(STEP) : KW'(rem_q);
  assign rem_nxt = rem_q - SHW'(k);

  mips_shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data_i (work_q),
    .op_i   (op_q),
    .k_i    (k),
    .fill_i (fill_q),
    .data_o (step_out)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    result_d = result_q;
    rem_d    = rem_q;
    fill_d   = fill_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          work_d = Data_in;
          op_d   = op_in;
          rem_d  = Shamt;
          fill_d = (op_in == SRA) ? Data_in[WIDTH-1] : 1'b0;
          if (passthru) begin
            state_d  = DONE;
            result_d = Data_in;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Start is deliberately not looked at here; the captured operands stay in charge.
        work_d = step_out;
        rem_d  = rem_nxt;
        if (rem_nxt == '0) begin
          state_d  = DONE;
          result_d = step_out;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      op_q     <= SLL;
      work_q   <= '0;
      result_q <= '0;
      rem_q    <= '0;
      fill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      fill_q   <= fill_d;
    end
  end

  assign Result = result_q;
  assign Busy   = (state_q == SHIFT);
  assign Done   = (state_q == DONE);

endmodule

// File: tb/tb_mips_seq_shifter.sv
// Self-checking bench for mips_seq_shifter (WIDTH=32, STEP=4) against an arithmetic reference model.
module tb_mips_seq_shifter;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;
  localparam int SHW   = 5;

  logic              CLK;
  logic              RST;
  logic              Start;
  logic [1:0]        Op;
  logic [SHW-1:0]    Shamt;
  logic [WIDTH-1:0]  Data_in;
  logic [WIDTH-1:0]  Result;
  logic              Busy;
  logic              Done;

  int checks = 0;
  int errors = 0;

  mips_seq_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .Start   (Start),
    .Op      (Op),
    .Shamt   (Shamt),
    .Data_in (Data_in),
    .Result  (Result),
    .Busy    (Busy),
    .Done    (Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

`ifdef SEQ_SHIFTER_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] ref_result(input logic [1:0] op, input int sh,
                                                  input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00: r = d << sh;
      2'b01: r = d >> sh;
      2'b10: r = $signed(d) >>> sh;
      default: begin
        if (ROT_EN && sh != 0) r = (d >> sh) | (d << (WIDTH - sh));
        else                   r = d;
      end
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input int sh);
    if (sh == 0 || (op == 2'b11 && !ROT_EN)) return 1;
    return 1 + (sh + STEP - 1) / STEP;
  endfunction

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    Data_in = $urandom;
    Op      = 2'($urandom_range(3, 0));
    Shamt   = SHW'($urandom_range(31, 0));
  endtask

  // Issues one operation, optionally pulsing Start again at cycle 'glitch' while shifting.
  task automatic run_op(input string tag, input logic [1:0] op, input int sh,
                        input logic [WIDTH-1:0] d, input int glitch);
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] held;
    int lat, cyc, busy_n;
    bit stable;
    exp    = ref_result(op, sh, d);
    lat    = ref_latency(op, sh);
    held   = Result;
    stable = 1'b1;
    Op = op; Shamt = SHW'(sh); Data_in = d; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    scramble();
    cyc = 1; busy_n = 0;
    while (!Done && cyc < 40) begin
      if (Busy) busy_n++;
      if (Result !== held) stable = 1'b0;
      Start = (cyc == glitch);
      if (cyc == glitch) scramble();
      @(posedge CLK); #1;
      Start = 1'b0;
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(lat));
    check({tag, "_busy"}, 32'(busy_n), 32'(lat - 1));
    check({tag, "_res"}, Result, exp);
    check({tag, "_stable"}, {31'd0, stable}, 32'd1);
    @(posedge CLK); #1;
    check({tag, "_pulse"}, {31'd0, Done}, 32'd0);
    check({tag, "_hold"}, Result, exp);
  endtask

  initial begin
    int saw_done;
    logic [1:0] rop;
    int rsh;
    RST = 1'b1; Start = 1'b0; Op = 2'b00; Shamt = '0; Data_in = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_result", Result, 32'h0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    run_op("sll2", 2'b00, 2, 32'h0000_0001, 0);
    run_op("sra31", 2'b10, 31, 32'h8000_0000, 0);
    run_op("srl31", 2'b01, 31, 32'h8000_0000, 0);
    run_op("sll0", 2'b00, 0, 32'hDEAD_BEEF, 0);
    run_op("srl0", 2'b01, 0, 32'h1234_5678, 0);
    run_op("sra0", 2'b10, 0, 32'h8765_4321, 0);
    run_op("rot0", 2'b11, 0, 32'hA5A5_0F0F, 0);
    run_op("rotr4", 2'b11, 4, 32'h0000_00F1, 0);
    run_op("sra_ignore", 2'b10, 30, 32'h9000_0001, 2);
    run_op("sll31", 2'b00, 31, 32'h0000_0003, 0);
    run_op("srl5", 2'b01, 5, 32'hFFFF_FFFF, 0);

    // Back-to-back: a new Start presented while Done is high is taken without an idle cycle.
    Op = 2'b00; Shamt = 5'd0; Data_in = 32'h0000_0003; Start = 1'b1;
    @(posedge CLK); #1;
    check("b2b_first_done", {31'd0, Done}, 32'd1);
    check("b2b_first_res", Result, 32'h0000_0003);
    Op = 2'b00; Shamt = 5'd4; Data_in = 32'h0000_0003; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    check("b2b_busy", {31'd0, Busy}, 32'd1);
    check("b2b_mid_done", {31'd0, Done}, 32'd0);
    @(posedge CLK); #1;
    check("b2b_second_done", {31'd0, Done}, 32'd1);
    check("b2b_second_res", Result, 32'h0000_0030);
    @(posedge CLK); #1;

    // Reset in the middle of a long shift: everything clears and no Done follows.
    Op = 2'b10; Shamt = 5'd31; Data_in = 32'h8000_0000; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    @(posedge CLK); #1;
    check("mid_busy", {31'd0, Busy}, 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("abort_result", Result, 32'h0);
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_done", {31'd0, Done}, 32'd0);
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      if (Done || Busy) saw_done++;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);

    for (int n = 0; n < 30; n++) begin
      rop = 2'($urandom_range(3, 0));
      rsh = (n % 5 == 0) ? 0 : int'($urandom_range(31, 0));
      run_op($sformatf("rand%0d", n), rop, rsh, $urandom, (n % 3 == 0) ? 2 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
